// File: rtl/mem_stage_ctl.sv
// MEM-stage controller: issues data-cache load/store over req/ack and holds the MEM/WB pipeline register.
// Latency: non-memop 1 cycle; memop acked N cycles after the request costs N stall cycles.
// Backpressure: stall freezes upstream stages while an access is outstanding; it drops in the ack/timeout cycle.
module mem_stage_ctl #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_in,
    input  logic [15:0] alu_in,
    input  logic [15:0] data_in,
    input  logic [3:0]  rd_addr_in,
    input  logic [1:0]  mem_signals_in,
    input  logic [2:0]  wb_signals_in,
    output logic        dc_req,
    output logic        dc_we,
    output logic [15:0] dc_addr,
    output logic [15:0] dc_wdata,
    input  logic [15:0] dc_rdata,
    input  logic        dc_ack,
    output logic        stall,
    output logic [15:0] pc_out,
    output logic [15:0] alu_out,
    output logic [15:0] mem_data_out,
    output logic [3:0]  rd_addr_out,
    output logic [2:0]  wb_signals_out,
    output logic        wb_valid,
    output logic        bus_err
);

    localparam logic [7:0] TMO = 8'(ACK_TIMEOUT);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] pc_q, pc_d, alu_q, alu_d, md_q, md_d;
    logic [3:0]  rd_q, rd_d;
    logic [2:0]  wb_q, wb_d;
    logic        vld_q, vld_d;
    logic        err_q, err_d;

    logic memop, is_load, is_store, timeout, done;

    // Decode of the EX/MEM control and completion of the outstanding access.
    always_comb begin
        memop    = |mem_signals_in;
        is_store = mem_signals_in[1];
        is_load  = (mem_signals_in == 2'b01);
        timeout  = (state_q == ST_WAIT) && (cnt_q == TMO) && !dc_ack;
        done     = (state_q == ST_WAIT) && (dc_ack || timeout);
    end

    // Cache request and stall are Mealy outputs, forced low by reset without waiting for a clock.
    always_comb begin
        dc_req   = rst && (((state_q == ST_IDLE) && memop) || ((state_q == ST_WAIT) && !timeout));
        dc_we    = is_store;
        dc_addr  = alu_in;
        dc_wdata = data_in;
        stall    = rst && memop && !done;
    end

    // Next state, wait counter, MEM/WB register and sticky bus error.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        alu_d   = alu_q;
        md_d    = md_q;
        rd_d    = rd_q;
        wb_d    = wb_q;
        vld_d   = vld_q;
        err_d   = err_q || (mem_signals_in == 2'b11);
        case (state_q)
            ST_IDLE: begin
                if (!memop) begin
                    pc_d  = pc_in;
                    alu_d = alu_in;
                    rd_d  = rd_addr_in;
                    wb_d  = wb_signals_in;
                    md_d  = 16'h0000;
                    vld_d = 1'b1;
                end else begin
                    // Bubble: only validity and WB control are cleared, data fields hold.
                    vld_d   = 1'b0;
                    wb_d    = 3'b000;
                    state_d = ST_WAIT;
                    cnt_d   = 8'd0;
                end
            end
            ST_WAIT: begin
                if (done) begin
                    pc_d    = pc_in;
                    alu_d   = alu_in;
                    rd_d    = rd_addr_in;
                    wb_d    = wb_signals_in;
                    vld_d   = 1'b1;
                    state_d = ST_IDLE;
                    if (!is_load) begin
                        md_d = 16'h0000;
                    end else if (timeout) begin
                        md_d = 16'hFFFF;
                    end else begin
                        md_d = dc_rdata;
                    end
                    if (timeout) begin
                        err_d = 1'b1;
                    end
                end else begin
                    vld_d = 1'b0;
                    wb_d  = 3'b000;
                    // Saturate so a misconfigured timeout can never wrap back to zero.
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and MEM/WB register update; reset abandons any outstanding access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            pc_q    <= 16'h0000;
            alu_q   <= 16'h0000;
            md_q    <= 16'h0000;
            rd_q    <= 4'h0;
            wb_q    <= 3'b000;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            alu_q   <= alu_d;
            md_q    <= md_d;
            rd_q    <= rd_d;
            wb_q    <= wb_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    // Register outputs.
    always_comb begin
        pc_out         = pc_q;
        alu_out        = alu_q;
        mem_data_out   = md_q;
        rd_addr_out    = rd_q;
        wb_signals_out = wb_q;
        wb_valid       = vld_q;
        bus_err        = err_q;
    end

endmodule

// File: tb/tb_mem_stage_ctl.sv
module tb_mem_stage_ctl;

    localparam int TMO = 4;

    logic        clk;
    logic        rst;
    logic [15:0] pc_in, alu_in, data_in;
    logic [3:0]  rd_addr_in;
    logic [1:0]  mem_signals_in;
    logic [2:0]  wb_signals_in;
    logic        dc_req, dc_we;
    logic [15:0] dc_addr, dc_wdata, dc_rdata;
    logic        dc_ack;
    logic        stall;
    logic [15:0] pc_out, alu_out, mem_data_out;
    logic [3:0]  rd_addr_out;
    logic [2:0]  wb_signals_out;
    logic        wb_valid, bus_err;

    int errors = 0;
    int checks = 0;

    // Transaction-level reference view of the MEM/WB register.
    logic [15:0] m_pc, m_alu, m_md;
    logic [3:0]  m_rd;
    logic [2:0]  m_wb;
    logic        m_valid, m_err;

    mem_stage_ctl #(.ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .pc_in(pc_in), .alu_in(alu_in), .data_in(data_in),
        .rd_addr_in(rd_addr_in), .mem_signals_in(mem_signals_in), .wb_signals_in(wb_signals_in),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_rdata(dc_rdata), .dc_ack(dc_ack), .stall(stall),
        .pc_out(pc_out), .alu_out(alu_out), .mem_data_out(mem_data_out),
        .rd_addr_out(rd_addr_out), .wb_signals_out(wb_signals_out),
        .wb_valid(wb_valid), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".pc_out"}, pc_out, m_pc);
        chk({tag, ".alu_out"}, alu_out, m_alu);
        chk({tag, ".mem_data_out"}, mem_data_out, m_md);
        chk({tag, ".rd_addr_out"}, 16'(rd_addr_out), 16'(m_rd));
        chk({tag, ".wb_signals_out"}, 16'(wb_signals_out), 16'(m_wb));
        chk({tag, ".wb_valid"}, 16'(wb_valid), 16'(m_valid));
        chk({tag, ".bus_err"}, 16'(bus_err), 16'(m_err));
    endtask

    task automatic model_reset();
        m_pc = 0; m_alu = 0; m_md = 0; m_rd = 0; m_wb = 0; m_valid = 0; m_err = 0;
    endtask

    // One instruction through MEM. n = cycles from request to ack (0 = cache never acks).
    // Called right after a rising edge; returns right after the edge that retires the instruction.
    task automatic do_op(input string tag, input logic [15:0] pc, input logic [15:0] alu,
                         input logic [15:0] dat, input logic [3:0] rd, input logic [1:0] ms,
                         input logic [2:0] wb, input int n, input logic [15:0] rdata);
        bit acked;
        int fin;
        int stalls;
        bit exp_stall, exp_req;
        pc_in = pc; alu_in = alu; data_in = dat; rd_addr_in = rd;
        mem_signals_in = ms; wb_signals_in = wb;
        if (ms == 2'b00) begin
            // A stray ack outside an access must be ignored.
            dc_ack   = 1'($urandom_range(0, 1));
            dc_rdata = 16'($urandom);
            @(negedge clk);
            chk({tag, ".stall"}, 16'(stall), 16'd0);
            chk({tag, ".dc_req"}, 16'(dc_req), 16'd0);
            @(posedge clk); #1;
            dc_ack = 1'b0;
            m_pc = pc; m_alu = alu; m_rd = rd; m_wb = wb; m_md = 16'h0000; m_valid = 1'b1;
            check_regs(tag);
        end else begin
            acked  = (n >= 1) && (n <= TMO + 1);
            fin    = acked ? n : TMO + 1;
            stalls = 0;
            for (int c = 0; c <= fin; c++) begin
                dc_ack   = (n > 0) && (c == n);
                dc_rdata = (c == n) ? rdata : 16'($urandom);
                @(negedge clk);
                exp_stall = (c < fin);
                exp_req   = (c < fin) || acked;
                chk({tag, ".stall"}, 16'(stall), 16'(exp_stall));
                chk({tag, ".dc_req"}, 16'(dc_req), 16'(exp_req));
                if (stall) stalls++;
                if (exp_req) begin
                    chk({tag, ".dc_we"}, 16'(dc_we), 16'(ms[1]));
                    chk({tag, ".dc_addr"}, dc_addr, alu);
                    chk({tag, ".dc_wdata"}, dc_wdata, dat);
                end
                @(posedge clk); #1;
                if (c < fin) begin
                    m_valid = 1'b0; m_wb = 3'b000;
                    if (ms == 2'b11) m_err = 1'b1;
                end else begin
                    m_pc = pc; m_alu = alu; m_rd = rd; m_wb = wb; m_valid = 1'b1;
                    if (ms == 2'b01) m_md = acked ? rdata : 16'hFFFF;
                    else m_md = 16'h0000;
                    if (!acked) m_err = 1'b1;
                end
                check_regs(tag);
            end
            dc_ack = 1'b0;
            chk({tag, ".stall_cycles"}, 16'(stalls), 16'(fin));
        end
    endtask

    initial begin
        rst = 1'b0;
        pc_in = 0; alu_in = 0; data_in = 0; rd_addr_in = 0; mem_signals_in = 0; wb_signals_in = 0;
        dc_rdata = 0; dc_ack = 0;
        model_reset();

        // Reset state.
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_regs("reset");
        chk("reset.dc_req", 16'(dc_req), 16'd0);
        chk("reset.stall", 16'(stall), 16'd0);
        rst = 1'b1;

        // Directed steps.
        do_op("alu",   16'h0100, 16'h0042, 16'h0000, 4'd3, 2'b00, 3'b101, 0, 16'h0);
        do_op("load3", 16'h0102, 16'h1000, 16'h5555, 4'd4, 2'b01, 3'b011, 3, 16'hBEEF);
        do_op("store", 16'h0104, 16'h2002, 16'h1234, 4'd0, 2'b10, 3'b000, 1, 16'h7777);
        do_op("b2b_a", 16'h0106, 16'h3000, 16'h0000, 4'd5, 2'b01, 3'b001, 1, 16'hA5A5);
        do_op("b2b_b", 16'h0108, 16'h3002, 16'h0000, 4'd6, 2'b01, 3'b001, 1, 16'h5A5A);
        do_op("tmo",   16'h010A, 16'h4000, 16'h0000, 4'd7, 2'b01, 3'b010, 0, 16'h0);
        do_op("post1", 16'h010C, 16'h0001, 16'h0000, 4'd8, 2'b00, 3'b100, 0, 16'h0);
        do_op("post2", 16'h010E, 16'h0002, 16'h0000, 4'd9, 2'b00, 3'b110, 0, 16'h0);

        // Reset two cycles into a WAIT: request outputs drop without a clock.
        pc_in = 16'h0200; alu_in = 16'h5000; data_in = 0; rd_addr_in = 4'd2;
        mem_signals_in = 2'b01; wb_signals_in = 3'b001;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("rstwait.dc_req", 16'(dc_req), 16'd0);
        chk("rstwait.stall", 16'(stall), 16'd0);
        pc_in = 0; alu_in = 0; rd_addr_in = 0; mem_signals_in = 0; wb_signals_in = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_regs("rstrel");
        chk("rstrel.dc_req", 16'(dc_req), 16'd0);
        chk("rstrel.stall", 16'(stall), 16'd0);
        @(posedge clk); #1;
        m_valid = 1'b1;
        check_regs("rstidle");
        do_op("after_rst", 16'h0300, 16'h6000, 16'h0000, 4'd1, 2'b01, 3'b111, 2, 16'hC0DE);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            int sel;
            logic [1:0] ms;
            sel = int'($urandom_range(0, 9));
            ms  = (sel < 4) ? 2'b00 : (sel < 7) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
            do_op("rand", 16'($urandom), 16'($urandom), 16'($urandom), 4'($urandom),
                  ms, 3'($urandom), int'($urandom_range(0, 6)), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctl.md
# mem_stage_ctl

MEM-stage controller of the 5-stage 16-bit pipeline; it consumes the EX/MEM pipeline register outputs and runs data-cache load/store transactions over a req/ack handshake. It drives `stall`, which holds the upstream stage write enables low while a cache access is outstanding. It also contains the MEM/WB pipeline register, presenting loaded data and pass-through fields to writeback.

## Interface
- `ACK_TIMEOUT`, default 255: maximum WAIT cycles without `dc_ack` before the access is aborted; legal range 1..255.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pc_in`  in  16  PC from EX/MEM.
- `alu_in`  in  16  ALU result, used as the memory address.
- `data_in`  in  16  store data (reg2 value).
- `rd_addr_in`  in  4  register-file write address.
- `mem_signals_in`  in  2  bit0 = load, bit1 = store.
- `wb_signals_in`  in  3  WB control, passed through.
- `dc_req`  out  1  cache request.
- `dc_we`  out  1  1 = store, 0 = load; valid while `dc_req` is high.
- `dc_addr`  out  16  cache address.
- `dc_wdata`  out  16  store data.
- `dc_rdata`  in  16  load data; valid with `dc_ack`.
- `dc_ack`  in  1  one-cycle completion pulse from the cache.
- `stall`  out  1  high freezes PC, IF/ID, ID/EX and EX/MEM.
- `pc_out`, `alu_out`, `mem_data_out`  out  16 each  MEM/WB register.
- `rd_addr_out`  out  4  MEM/WB register.
- `wb_signals_out`  out  3  MEM/WB register; zero when the entry is a bubble.
- `wb_valid`  out  1  MEM/WB entry is a real instruction.
- `bus_err`  out  1  sticky; set on timeout, cleared only by reset.

## Operation
- Memory op ("memop") = `mem_signals_in != 0`. If both bits are set, the op is a store and `bus_err` is set.
- FSM has two states: IDLE and WAIT.
- IDLE, no memop:
  - The MEM/WB register loads `pc_in`, `alu_in`, `rd_addr_in` and `wb_signals_in`.
  - `mem_data_out` loads 0 and `wb_valid` loads 1.
  - `stall` stays 0.
- IDLE, memop:
  - `dc_req` = 1 combinationally (Mealy output), with `dc_we` = store, `dc_addr` = `alu_in`, `dc_wdata` = `data_in`.
  - `stall` = 1.
  - The MEM/WB register loads a bubble: `wb_valid` = 0, `wb_signals_out` = 0, other fields held.
  - Next state is WAIT, and the wait counter clears to 0.
- WAIT, `dc_ack` = 0:
  - `dc_req` stays 1, and `dc_*` track the EX/MEM inputs, which are held by `stall`.
  - `stall` = 1, a bubble is loaded, and the counter increments.
- WAIT, `dc_ack` = 1:
  - `stall` = 0 in this same cycle.
  - The MEM/WB register loads the instruction; `mem_data_out` = `dc_rdata` for a load, or 0 for a store.
  - `wb_valid` = 1 and the next state is IDLE.
- WAIT, counter == `ACK_TIMEOUT` with no ack:
  - Treated exactly like an ack, except `mem_data_out` = 16'hFFFF for a load.
  - `bus_err` is set to 1 and `dc_req` drops in this cycle.
- `dc_ack` in IDLE is ignored.
- The counter is 8 bits and saturates; it never wraps.
- `stall` = memop && !(WAIT && (`dc_ack` || timeout)).

## Timing
- Reset (`rst` = 0, asynchronous):
  - State = IDLE and counter = 0.
  - All MEM/WB outputs = 0, `wb_valid` = 0, `bus_err` = 0.
  - `dc_req` = 0 immediately. An outstanding cache access is abandoned; the cache is reset by the same `rst`.
- Non-memop: MEM/WB outputs are valid 1 cycle after the EX/MEM outputs.
- Memop with ack N ≥ 1 cycles after the request cycle: `stall` is high for N cycles, and `wb_valid` rises at the edge that ends the ack cycle.
  - Minimum cost is 1 stall cycle.
- `dc_ack` must not arrive in the request cycle; the cache acks no earlier than 1 cycle after it.
- Back-to-back memops: after the ack cycle, the next memop is in EX/MEM on the following cycle. IDLE issues it immediately, with no dead cycle.
- `dc_addr`, `dc_we` and `dc_wdata` are stable for the entire time `dc_req` is high.

## Test plan
- Reset, then ALU op (`alu_in` = 16'h0042, `rd_addr_in` = 3, `wb_signals_in` = 3'b101, `mem_signals_in` = 0) -> next cycle `alu_out` = 16'h0042, `rd_addr_out` = 3, `wb_valid` = 1; `stall` never asserts.
- Load at 16'h1000, cache acks 3 cycles after the request with `dc_rdata` = 16'hBEEF -> `stall` is high for 3 cycles; `wb_valid` = 0 during the stall; then `mem_data_out` = 16'hBEEF and `wb_valid` = 1.
- Store of 16'h1234 to 16'h2002, ack after 1 cycle -> `dc_we` = 1 and `dc_wdata` = 16'h1234 throughout the request; exactly 1 stall cycle; `mem_data_out` = 0.
- Load with `ACK_TIMEOUT` = 4 and no ack -> `stall` is high for 5 cycles; `mem_data_out` = 16'hFFFF; `bus_err` = 1 and stays 1 through later normal ops.
- `rst` pulled low 2 cycles into a WAIT -> `dc_req` and `stall` go 0 without waiting for a clock; after release, state is IDLE and all outputs are 0.
- Two back-to-back loads, each acked after 1 cycle -> the second `dc_req` rises the cycle after the first ack; `wb_valid` pattern is 0,1,0,1.
